pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch front end of the RV32IM pipeline. It owns the program counter and the IF/ID pipeline register, and it sits directly downstream of the branch-decision logic in EX. It consumes that logic's PC-select decision together with the computed branch/jump target. On a taken branch it redirects fetch, squashes the wrong-path instructions, and survives an instruction memory that is still busy at the moment the redirect arrives.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) inserted into IF/ID as a bubble
- CLK  in  1  single clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- PC_SEL  in  1  taken-branch/jump decision from EX; must be settled before the rising edge
- BRANCH_TARGET  in  32  redirect address from EX, valid when PC_SEL=1
- STALL  in  1  load-use hold from the hazard unit
- IMEM_BUSY  in  1  instruction memory has not yet returned the word for PC
- INSTR_IN  in  32  instruction word for the current PC, valid when IMEM_BUSY=0
- PC  out  32  fetch address driven to instruction memory
- IF_ID_PC  out  32  PC of the instruction held in IF/ID
- IF_ID_INSTR  out  32  instruction held in IF/ID
- IF_ID_VALID  out  1  IF/ID holds a real instruction, not a bubble
- FLUSH  out  1  one-cycle pulse; ID/EX must squash its contents
- MISALIGN  out  1  one-cycle pulse; an accepted redirect target had bit 1 set

## Operation
- States: RUN, WAIT (memory busy, no redirect pending), REDIR (redirect pending behind a busy memory).
- Redirect target is {BRANCH_TARGET[31:1],1'b0}. Bit 0 is always cleared, which covers JALR. Bit 1 is kept and flagged through MISALIGN in the same cycle the redirect is accepted.
- Priority at every edge: RESET > PC_SEL > STALL > IMEM_BUSY > normal advance.
- Normal advance (RUN or WAIT, PC_SEL=0, STALL=0, IMEM_BUSY=0):
  - PC <= PC+4; the add wraps modulo 2^32, so 0xFFFF_FFFC goes to 0.
  - IF/ID <= {PC, INSTR_IN, valid=1}.
  - State goes to RUN.
- Busy (PC_SEL=0, STALL=0, IMEM_BUSY=1):
  - PC holds.
  - IF/ID <= {PC, NOP_INSTR, valid=0}.
  - State goes to WAIT.
- STALL=1 with PC_SEL=0: PC, IF/ID and state all hold, regardless of IMEM_BUSY.
- PC_SEL=1 with IMEM_BUSY=0, in any state:
  - PC <= target.
  - IF/ID <= bubble.
  - FLUSH=1 for the next cycle.
  - State goes to RUN.
- PC_SEL=1 with IMEM_BUSY=1:
  - Latch target into a pending register.
  - PC holds, because the memory transaction must complete.
  - IF/ID <= bubble.
  - FLUSH pulses.
  - State goes to REDIR.
- REDIR with IMEM_BUSY=0 and PC_SEL=0:
  - The returned word is discarded.
  - PC <= pending target.
  - IF/ID <= bubble.
  - State goes to RUN.
  - FLUSH is not pulsed again.
- REDIR with IMEM_BUSY=1: hold; STALL is ignored in this state, since only bubbles are issued.
- REDIR with PC_SEL=1 (a newer redirect):
  - The pending target is overwritten.
  - FLUSH pulses.
  - If IMEM_BUSY=0 the new target is loaded into PC directly.

## Timing
- Reset values:
  - PC=RESET_PC
  - IF_ID_PC=RESET_PC
  - IF_ID_INSTR=NOP_INSTR
  - IF_ID_VALID=0
  - FLUSH=0
  - MISALIGN=0
  - state=RUN
  - pending target=0
- Reset takes effect on the first edge where RESET=1 and overrides any in-flight redirect or pending target.
- All outputs are registered. Nothing passes combinationally from input to output.
- Redirect latency: PC_SEL sampled at edge N gives PC=target after edge N, the first target fetch in cycle N+1, and FLUSH high during cycle N+1 only.
- With a busy memory, PC=target appears one cycle after the edge where IMEM_BUSY is first sampled low in REDIR.
- Taken-branch penalty: 2 bubbles (IF/ID and ID/EX), with no further loss when memory is ready.
- Steady state: one instruction per cycle while IMEM_BUSY=0 and STALL=0.

## Structure
- Shared pipeline package holds:
  - NOP_INSTR and the RESET_PC default
  - the state encoding (RUN=2'd0, WAIT=2'd1, REDIR=2'd2)
  - the IF/ID field widths, which are also used by the decode stage
- One natural sub-module, if_id_reg: holds PC/INSTR/VALID, with load, hold and bubble controls.
- The PC register, pending-target register and FSM stay in pc_fetch_unit.

## Test plan
- Reset then 4 cycles of IMEM_BUSY=0 with INSTR_IN=0x00A00093 -> PC 0,4,8,C,10; IF_ID_VALID=1 from cycle 2; IF_ID_PC lags PC by one fetch.
- PC_SEL=1 with BRANCH_TARGET=0x0000_0101 while at PC=0x20 -> PC=0x100 next cycle, FLUSH high exactly one cycle, IF/ID bubble, MISALIGN=0.
- IMEM_BUSY=1 at PC=0x40, PC_SEL=1 with target 0x200, then busy for 3 more cycles -> PC holds 0x40 through REDIR, single FLUSH pulse, returned word never reaches IF/ID, PC=0x200 after busy drops.
- STALL=1 and PC_SEL=1 together at PC=0x80 with target 0x300 -> redirect wins: PC=0x300, FLUSH=1; then STALL=1 alone -> PC and IF/ID frozen.
- PC=0xFFFF_FFFC with normal advance -> PC=0x0000_0000; a target of 0x0000_0402 -> PC=0x402 and MISALIGN pulses.
- RESET asserted in REDIR with a pending target of 0x500 -> PC=RESET_PC, state RUN; no later jump to 0x500 once IMEM_BUSY drops.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch/decode constants, FSM encoding and IF/ID layout
package pc_fetch_unit_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2
  } state_e;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               bub,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output if_id_t             if_id_q
);
  if_id_t if_id_d;
  // load a fetched word, insert a bubble tagged with the current PC, or hold
  always_comb begin
    if_id_d = if_id_q;
    if (ld) if_id_d = {pc_in, instr_in, 1'b1};
    else if (bub) if_id_d = {pc_in, NOP_INSTR, 1'b0};
  end
  // register update; reset leaves a bubble at RESET_PC
  always_ff @(posedge clk) begin
    if (rst) if_id_q <= {RESET_PC, NOP_INSTR, 1'b0};
    else if_id_q <= if_id_d;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, redirect handling and IF/ID front end
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PC_SEL,
  input  logic [PC_W-1:0]    BRANCH_TARGET,
  input  logic               STALL,
  input  logic               IMEM_BUSY,
  input  logic [INSTR_W-1:0] INSTR_IN,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    IF_ID_PC,
  output logic [INSTR_W-1:0] IF_ID_INSTR,
  output logic               IF_ID_VALID,
  output logic               FLUSH,
  output logic               MISALIGN
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_q, pend_d, tgt;
  logic flush_q, flush_d, mis_q, mis_d, ld, bub;
  if_id_t if_id;
  assign tgt = {BRANCH_TARGET[PC_W-1:1], 1'b0};
  // next state in priority order: new redirect, pending redirect, stall, busy, advance
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    flush_d = 1'b0;
    mis_d = 1'b0;
    ld = 1'b0;
    bub = 1'b0;
    if (PC_SEL) begin
      pend_d = tgt;
      flush_d = 1'b1;
      mis_d = tgt[1];
      bub = 1'b1;
      pc_d = IMEM_BUSY ? pc_q : tgt;
      state_d = IMEM_BUSY ? REDIR : RUN;
    end else if (state_q == REDIR) begin
      bub = 1'b1;
      pc_d = IMEM_BUSY ? pc_q : pend_q;
      state_d = IMEM_BUSY ? REDIR : RUN;
    end else if (!STALL) begin
      ld = !IMEM_BUSY;
      bub = IMEM_BUSY;
      pc_d = IMEM_BUSY ? pc_q : pc_q + PC_W'(4);
      state_d = IMEM_BUSY ? WAIT : RUN;
    end
  end
  // PC, pending target, FSM and pulse registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      pend_q <= '0;
      flush_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      flush_q <= flush_d;
      mis_q <= mis_d;
    end
  end
  if_id_reg u_if_id (
    .clk(CLK),
    .rst(RESET),
    .ld(ld),
    .bub(bub),
    .pc_in(pc_q),
    .instr_in(INSTR_IN),
    .if_id_q(if_id)
  );
  assign PC = pc_q;
  assign IF_ID_PC = if_id.pc;
  assign IF_ID_INSTR = if_id.instr;
  assign IF_ID_VALID = if_id.valid;
  assign FLUSH = flush_q;
  assign MISALIGN = mis_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifin;
    logic        v;
    logic        fl;
    logic        mis;
  } exp_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA = 32'h00A0_0093;
  localparam logic [31:0] IB = 32'h0020_8133;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  logic CLK = 1'b0, RESET, PC_SEL, STALL, IMEM_BUSY;
  logic [31:0] BRANCH_TARGET, INSTR_IN, PC, IF_ID_PC, IF_ID_INSTR;
  logic IF_ID_VALID, FLUSH, MISALIGN;
  int checks = 0, failures = 0;
  exp_t sb[$];
  pc_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .PC_SEL(PC_SEL), .BRANCH_TARGET(BRANCH_TARGET),
    .STALL(STALL), .IMEM_BUSY(IMEM_BUSY), .INSTR_IN(INSTR_IN), .PC(PC),
    .IF_ID_PC(IF_ID_PC), .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_VALID(IF_ID_VALID),
    .FLUSH(FLUSH), .MISALIGN(MISALIGN)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic rst, input logic sel, input logic [31:0] tgt,
                      input logic stall, input logic busy, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] ifpc, input logic [31:0] ifin,
                      input logic v, input logic fl, input logic mis);
    exp_t e;
    sb.push_back('{pc, ifpc, ifin, v, fl, mis});
    RESET = rst;
    PC_SEL = sel;
    BRANCH_TARGET = tgt;
    STALL = stall;
    IMEM_BUSY = busy;
    INSTR_IN = instr;
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, PC, e.pc);
    chk({tag, ".ifpc"}, IF_ID_PC, e.ifpc);
    chk({tag, ".ifinstr"}, IF_ID_INSTR, e.ifin);
    chk({tag, ".valid"}, {31'd0, IF_ID_VALID}, {31'd0, e.v});
    chk({tag, ".flush"}, {31'd0, FLUSH}, {31'd0, e.fl});
    chk({tag, ".misalign"}, {31'd0, MISALIGN}, {31'd0, e.mis});
  endtask
  initial begin
    step("reset", 1, 1, 32'h500, 0, 0, IA, 32'h0, 32'h0, NOP, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("advance", 0, 0, 0, 0, 0, IA, 32'(4 * (i + 1)), 32'(4 * i), IA, 1, 0, 0);
    step("br101", 0, 1, 32'h101, 0, 0, IA, 32'h100, 32'h20, NOP, 0, 1, 0);
    step("after_br", 0, 0, 0, 0, 0, IB, 32'h104, 32'h100, IB, 1, 0, 0);
    step("br40", 0, 1, 32'h40, 0, 0, IB, 32'h40, 32'h104, NOP, 0, 1, 0);
    step("busy40", 0, 0, 0, 0, 1, JUNK, 32'h40, 32'h40, NOP, 0, 0, 0);
    step("redir_busy", 0, 1, 32'h200, 0, 1, JUNK, 32'h40, 32'h40, NOP, 0, 1, 0);
    step("redir_hold1", 0, 0, 0, 0, 1, JUNK, 32'h40, 32'h40, NOP, 0, 0, 0);
    step("redir_hold2", 0, 0, 0, 1, 1, JUNK, 32'h40, 32'h40, NOP, 0, 0, 0);
    step("redir_hold3", 0, 0, 0, 0, 1, JUNK, 32'h40, 32'h40, NOP, 0, 0, 0);
    step("redir_done", 0, 0, 0, 0, 0, JUNK, 32'h200, 32'h40, NOP, 0, 0, 0);
    step("after_redir", 0, 0, 0, 0, 0, IA, 32'h204, 32'h200, IA, 1, 0, 0);
    step("br80", 0, 1, 32'h80, 0, 0, IA, 32'h80, 32'h204, NOP, 0, 1, 0);
    step("stall_br", 0, 1, 32'h300, 1, 0, IA, 32'h300, 32'h80, NOP, 0, 1, 0);
    step("after_sbr", 0, 0, 0, 0, 0, IA, 32'h304, 32'h300, IA, 1, 0, 0);
    step("stall", 0, 0, 0, 1, 0, IB, 32'h304, 32'h300, IA, 1, 0, 0);
    step("stall_busy", 0, 0, 0, 1, 1, IB, 32'h304, 32'h300, IA, 1, 0, 0);
    step("unstall", 0, 0, 0, 0, 0, IA, 32'h308, 32'h304, IA, 1, 0, 0);
    step("br_top", 0, 1, 32'hFFFF_FFFC, 0, 0, IA, 32'hFFFF_FFFC, 32'h308, NOP, 0, 1, 0);
    step("wrap", 0, 0, 0, 0, 0, IA, 32'h0, 32'hFFFF_FFFC, IA, 1, 0, 0);
    step("br402", 0, 1, 32'h402, 0, 0, IA, 32'h402, 32'h0, NOP, 0, 1, 1);
    step("after_mis", 0, 0, 0, 0, 0, IB, 32'h406, 32'h402, IB, 1, 0, 0);
    step("busy406", 0, 0, 0, 0, 1, JUNK, 32'h406, 32'h406, NOP, 0, 0, 0);
    step("redir500", 0, 1, 32'h500, 0, 1, JUNK, 32'h406, 32'h406, NOP, 0, 1, 0);
    step("redir_hold", 0, 0, 0, 0, 1, JUNK, 32'h406, 32'h406, NOP, 0, 0, 0);
    step("redir600", 0, 1, 32'h601, 0, 1, JUNK, 32'h406, 32'h406, NOP, 0, 1, 0);
    step("reset_redir", 1, 0, 0, 0, 1, JUNK, 32'h0, 32'h0, NOP, 0, 0, 0);
    step("post_reset0", 0, 0, 0, 0, 0, IA, 32'h4, 32'h0, IA, 1, 0, 0);
    step("post_reset1", 0, 0, 0, 0, 0, IA, 32'h8, 32'h4, IA, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
